// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Function : RV32 load/store sequencer for a byte-lane data memory with
//            one-cycle read latency; splits lane-straddling accesses in two.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
    parameter int WIDTH            = 10,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_address,
    input  logic [31:0]      req_write_data,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic             resp_error,
    output logic [WIDTH-3:0] mem_address,
    output logic             mem_write_enable,
    output logic [31:0]      mem_write_data,
    output logic [3:0]       mem_mask_byte,
    input  logic [31:0]      mem_read_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic             r_write;
    logic [2:0]       r_funct3;
    logic [WIDTH-1:0] r_address;
    logic [31:0]      r_write_data;
    logic             r_error;
    logic [31:0]      r_low;
    logic             r_resp_valid;
    logic [31:0]      r_resp_data;
    logic             r_resp_error;

    logic             w_accept;
    logic             w_req_illegal;
    logic             w_req_misaligned;
    logic             w_req_error;
    logic [1:0]       w_offset;
    logic [3:0]       w_size_mask;
    logic [7:0]       w_mask_wide;
    logic [63:0]      w_data_wide;
    logic             w_straddle;
    logic [63:0]      w_pair;
    logic [31:0]      w_aligned;
    logic [31:0]      w_load_result;
    logic             w_unused;

    assign req_ready  = (r_state == IDLE) && !rst;
    assign w_accept   = req_valid && req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_error = r_resp_error;
    assign w_unused   = ^req_address[31:WIDTH];

    always_comb begin
        w_req_illegal    = 1'b0;
        w_req_misaligned = 1'b0;
        if (req_write) begin
            w_req_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        end else begin
            w_req_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
        end
        if ((req_funct3[1:0] == 2'b01) && req_address[0]) begin
            w_req_misaligned = 1'b1;
        end
        if ((req_funct3[1:0] == 2'b10) && (req_address[1:0] != 2'b00)) begin
            w_req_misaligned = 1'b1;
        end
    end

    assign w_req_error = w_req_illegal || (w_req_misaligned && !SPLIT_MISALIGNED);

    // Lane geometry of the latched request: the upper nibble of the wide mask
    // holds the lanes that spill into the following word.
    assign w_offset = r_address[1:0];

    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_size_mask = 4'b0001;
            2'b01:   w_size_mask = 4'b0011;
            default: w_size_mask = 4'b1111;
        endcase
    end

    assign w_mask_wide = {4'b0000, w_size_mask} << w_offset;
    assign w_data_wide = {32'h0000_0000, r_write_data} << {w_offset, 3'b000};
    assign w_straddle  = |w_mask_wide[7:4];
    assign w_pair      = w_straddle ? {mem_read_data, r_low} : {32'h0000_0000, mem_read_data};
    assign w_aligned   = 32'(w_pair >> {w_offset, 3'b000});

    always_comb begin
        case (r_funct3)
            3'b000:  w_load_result = {{24{w_aligned[7]}}, w_aligned[7:0]};
            3'b001:  w_load_result = {{16{w_aligned[15]}}, w_aligned[15:0]};
            3'b010:  w_load_result = w_aligned;
            3'b100:  w_load_result = {24'h000000, w_aligned[7:0]};
            3'b101:  w_load_result = {16'h0000, w_aligned[15:0]};
            default: w_load_result = 32'h0000_0000;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = w_req_error ? DONE : ACC0;
            ACC0:    w_state_next = w_straddle ? ACC1 : DONE;
            ACC1:    w_state_next = DONE;
            DONE:    if (r_resp_valid && resp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Writes are gated by rst so a reset landing mid-split stops the second half.
    always_comb begin
        mem_address      = r_address[WIDTH-1:2];
        mem_write_enable = 1'b0;
        mem_mask_byte    = 4'b0000;
        mem_write_data   = 32'h0000_0000;
        case (r_state)
            ACC0: begin
                mem_write_enable = r_write && !rst;
                mem_mask_byte    = w_mask_wide[3:0];
                mem_write_data   = w_data_wide[31:0];
            end
            ACC1: begin
                mem_address      = r_address[WIDTH-1:2] + (WIDTH-2)'(1);
                mem_write_enable = r_write && !rst;
                mem_mask_byte    = w_mask_wide[7:4];
                mem_write_data   = w_data_wide[63:32];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'h0000_0000;
            r_resp_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_write      <= req_write;
                r_funct3     <= req_funct3;
                r_address    <= req_address[WIDTH-1:0];
                r_write_data <= req_write_data;
                r_error      <= w_req_error;
            end
            if (r_state == ACC1) begin
                r_low <= mem_read_data;
            end
            if (r_state == DONE) begin
                if (!r_resp_valid) begin
                    r_resp_valid <= 1'b1;
                    r_resp_error <= r_error;
                    r_resp_data  <= (r_write || r_error) ? 32'h0000_0000 : w_load_result;
                end else if (resp_ready) begin
                    r_resp_valid <= 1'b0;
                    r_resp_error <= 1'b0;
                    r_resp_data  <= 32'h0000_0000;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Function : Directed self-checking bench for load_store_unit with byte-lane
//            memory models for a splitting and a non-splitting instance.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

    localparam int WIDTH = 10;
    localparam int AW    = WIDTH - 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_write;
    logic [2:0]    req_funct3;
    logic [31:0]   req_address;
    logic [31:0]   req_write_data;
    logic          resp_ready;

    logic          req_valid, req_ready, resp_valid, resp_error, mem_write_enable;
    logic [31:0]   resp_data, mem_write_data, mem_read_data;
    logic [3:0]    mem_mask_byte;
    logic [AW-1:0] mem_address;

    logic          ns_req_valid, ns_req_ready, ns_resp_valid, ns_resp_error, ns_mem_write_enable;
    logic [31:0]   ns_resp_data, ns_mem_write_data, ns_mem_read_data;
    logic [3:0]    ns_mem_mask_byte;
    logic [AW-1:0] ns_mem_address;

    load_store_unit #(.WIDTH(WIDTH), .SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_address(req_address), .req_write_data(req_write_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_error(resp_error), .mem_address(mem_address), .mem_write_enable(mem_write_enable),
        .mem_write_data(mem_write_data), .mem_mask_byte(mem_mask_byte), .mem_read_data(mem_read_data)
    );

    load_store_unit #(.WIDTH(WIDTH), .SPLIT_MISALIGNED(1'b0)) dut_ns (
        .clk(clk), .rst(rst),
        .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_address(req_address), .req_write_data(req_write_data),
        .resp_valid(ns_resp_valid), .resp_ready(resp_ready), .resp_data(ns_resp_data),
        .resp_error(ns_resp_error), .mem_address(ns_mem_address), .mem_write_enable(ns_mem_write_enable),
        .mem_write_data(ns_mem_write_data), .mem_mask_byte(ns_mem_mask_byte), .mem_read_data(ns_mem_read_data)
    );

    logic [31:0] mem    [0:(1<<AW)-1];
    logic [31:0] ns_mem [0:(1<<AW)-1];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr_count = 0;
    int ns_wr_count = 0;
    int accept_cyc = 0;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]    = 32'h0;
            ns_mem[i] = 32'h0;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write_enable) begin
            wr_count <= wr_count + 1;
            for (int b = 0; b < 4; b++)
                if (mem_mask_byte[b]) mem[mem_address][8*b +: 8] <= mem_write_data[8*b +: 8];
        end
        if (ns_mem_write_enable) begin
            ns_wr_count <= ns_wr_count + 1;
            for (int b = 0; b < 4; b++)
                if (ns_mem_mask_byte[b]) ns_mem[ns_mem_address][8*b +: 8] <= ns_mem_write_data[8*b +: 8];
        end
        mem_read_data    <= mem[mem_address];
        ns_mem_read_data <= ns_mem[ns_mem_address];
    end

    // Presents a request and returns #1 after the edge that accepted it.
    task automatic issue(input bit sel, input bit w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        int n;
        req_write = w; req_funct3 = f3; req_address = a; req_write_data = d;
        if (sel) ns_req_valid = 1'b1; else req_valid = 1'b1;
        n = 0;
        while (((sel ? ns_req_ready : req_ready) !== 1'b1) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n >= 20) begin
            failures++;
            $display("FAIL accept_timeout: req_ready=0 required 1");
        end
        @(posedge clk); #1;
        accept_cyc = cyc;
        req_valid = 1'b0; ns_req_valid = 1'b0;
    endtask

    task automatic wait_resp(input bit sel, output int lat);
        int n;
        n = 0;
        while (((sel ? ns_resp_valid : resp_valid) !== 1'b1) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        lat = cyc - accept_cyc;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
        rst = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_error !== 1'b0) begin failures++; $display("FAIL rst_resp_error: got %b expected 0", resp_error); end
        checks++; if (resp_data !== 32'h0) begin failures++; $display("FAIL rst_resp_data: got %h expected 0", resp_data); end
        checks++; if (mem_write_enable !== 1'b0) begin failures++; $display("FAIL rst_we: got %b expected 0", mem_write_enable); end
        checks++; if (mem_mask_byte !== 4'b0000) begin failures++; $display("FAIL rst_mask: got %b expected 0000", mem_mask_byte); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after: got %b expected 1", req_ready); end
    endtask

    task automatic test_aligned();
        int lat;
        issue(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        checks++; if (mem_address !== 8'h04) begin failures++; $display("FAIL sw_addr: got %h expected 04", mem_address); end
        checks++; if (mem_mask_byte !== 4'b1111) begin failures++; $display("FAIL sw_mask: got %b expected 1111", mem_mask_byte); end
        checks++; if (mem_write_enable !== 1'b1) begin failures++; $display("FAIL sw_we: got %b expected 1", mem_write_enable); end
        checks++; if (mem_write_data !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_wdata: got %h expected deadbeef", mem_write_data); end
        wait_resp(1'b0, lat);
        checks++; if (lat != 2) begin failures++; $display("FAIL sw_latency: got %0d expected 2", lat); end
        checks++; if (resp_data !== 32'h0 || resp_error !== 1'b0) begin failures++; $display("FAIL sw_resp: got %h/%b expected 0/0", resp_data, resp_error); end
        issue(1'b0, 1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (mem_write_enable !== 1'b0) begin failures++; $display("FAIL lw_we: got %b expected 0", mem_write_enable); end
        wait_resp(1'b0, lat);
        checks++; if (lat != 2) begin failures++; $display("FAIL lw_latency: got %0d expected 2", lat); end
        checks++; if (resp_data !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data: got %h expected deadbeef", resp_data); end
        checks++; if (resp_error !== 1'b0) begin failures++; $display("FAIL lw_error: got %b expected 0", resp_error); end
    endtask

    task automatic test_subword();
        int lat;
        issue(1'b0, 1'b1, 3'b000, 32'h21, 32'h80);
        checks++; if (mem_address !== 8'h08) begin failures++; $display("FAIL sb_addr: got %h expected 08", mem_address); end
        checks++; if (mem_mask_byte !== 4'b0010) begin failures++; $display("FAIL sb_mask: got %b expected 0010", mem_mask_byte); end
        checks++; if (mem_write_data !== 32'h00008000) begin failures++; $display("FAIL sb_wdata: got %h expected 00008000", mem_write_data); end
        wait_resp(1'b0, lat);
        issue(1'b0, 1'b0, 3'b000, 32'h21, 32'h0);
        wait_resp(1'b0, lat);
        checks++; if (resp_data !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_data: got %h expected ffffff80", resp_data); end
        issue(1'b0, 1'b0, 3'b100, 32'h21, 32'h0);
        wait_resp(1'b0, lat);
        checks++; if (resp_data !== 32'h00000080) begin failures++; $display("FAIL lbu_data: got %h expected 00000080", resp_data); end
    endtask

    task automatic test_split();
        int lat;
        issue(1'b0, 1'b1, 3'b010, 32'h40, 32'h44332211);
        wait_resp(1'b0, lat);
        issue(1'b0, 1'b1, 3'b010, 32'h44, 32'h88776655);
        wait_resp(1'b0, lat);
        issue(1'b0, 1'b0, 3'b010, 32'h42, 32'h0);
        checks++; if (mem_address !== 8'h10 || mem_mask_byte !== 4'b1100) begin failures++; $display("FAIL lw_split_acc0: got %h/%b expected 10/1100", mem_address, mem_mask_byte); end
        @(posedge clk); #1;
        checks++; if (mem_address !== 8'h11 || mem_mask_byte !== 4'b0011) begin failures++; $display("FAIL lw_split_acc1: got %h/%b expected 11/0011", mem_address, mem_mask_byte); end
        wait_resp(1'b0, lat);
        checks++; if (lat != 3) begin failures++; $display("FAIL lw_split_latency: got %0d expected 3", lat); end
        checks++; if (resp_data !== 32'h66554433) begin failures++; $display("FAIL lw_split_data: got %h expected 66554433", resp_data); end
        issue(1'b0, 1'b1, 3'b001, 32'h43, 32'h0000ABCD);
        checks++; if (mem_mask_byte !== 4'b1000 || mem_write_data !== 32'hCD000000) begin failures++; $display("FAIL sh_split_acc0: got %b/%h expected 1000/cd000000", mem_mask_byte, mem_write_data); end
        @(posedge clk); #1;
        checks++; if (mem_mask_byte !== 4'b0001 || mem_write_data !== 32'h000000AB) begin failures++; $display("FAIL sh_split_acc1: got %b/%h expected 0001/000000ab", mem_mask_byte, mem_write_data); end
        checks++; if (mem_address !== 8'h11 || mem_write_enable !== 1'b1) begin failures++; $display("FAIL sh_split_acc1_cmd: got %h/%b expected 11/1", mem_address, mem_write_enable); end
        wait_resp(1'b0, lat);
        issue(1'b0, 1'b0, 3'b010, 32'h40, 32'h0);
        wait_resp(1'b0, lat);
        checks++; if (resp_data !== 32'hCD332211) begin failures++; $display("FAIL sh_split_low_word: got %h expected cd332211", resp_data); end
        issue(1'b0, 1'b0, 3'b101, 32'h43, 32'h0);
        wait_resp(1'b0, lat);
        checks++; if (resp_data !== 32'h0000ABCD) begin failures++; $display("FAIL lhu_split_data: got %h expected 0000abcd", resp_data); end
    endtask

    task automatic test_wrap();
        int lat;
        issue(1'b0, 1'b1, 3'b010, 32'h0, 32'h12345678);
        wait_resp(1'b0, lat);
        issue(1'b0, 1'b0, 3'b010, 32'h3FE, 32'h0);
        checks++; if (mem_address !== 8'hFF) begin failures++; $display("FAIL wrap_acc0_addr: got %h expected ff", mem_address); end
        @(posedge clk); #1;
        checks++; if (mem_address !== 8'h00) begin failures++; $display("FAIL wrap_acc1_addr: got %h expected 00", mem_address); end
        wait_resp(1'b0, lat);
        checks++; if (resp_data !== 32'h56780000) begin failures++; $display("FAIL wrap_data: got %h expected 56780000", resp_data); end
    endtask

    task automatic test_errors();
        int lat;
        int wr0;
        wr0 = wr_count;
        issue(1'b0, 1'b0, 3'b011, 32'h10, 32'h0);
        wait_resp(1'b0, lat);
        checks++; if (lat != 1) begin failures++; $display("FAIL ill_load_latency: got %0d expected 1", lat); end
        checks++; if (resp_error !== 1'b1 || resp_data !== 32'h0) begin failures++; $display("FAIL ill_load_resp: got %b/%h expected 1/0", resp_error, resp_data); end
        issue(1'b0, 1'b1, 3'b100, 32'h10, 32'h11111111);
        wait_resp(1'b0, lat);
        checks++; if (resp_error !== 1'b1) begin failures++; $display("FAIL ill_store_error: got %b expected 1", resp_error); end
        checks++; if (wr_count != wr0) begin failures++; $display("FAIL ill_no_write: got %0d writes expected 0", wr_count - wr0); end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin failures++; $display("FAIL ill_mem: got %h expected deadbeef", mem[4]); end
        issue(1'b1, 1'b1, 3'b010, 32'h2, 32'hCAFEF00D);
        wait_resp(1'b1, lat);
        checks++; if (lat != 1) begin failures++; $display("FAIL ns_sw_latency: got %0d expected 1", lat); end
        checks++; if (ns_resp_error !== 1'b1 || ns_resp_data !== 32'h0) begin failures++; $display("FAIL ns_sw_resp: got %b/%h expected 1/0", ns_resp_error, ns_resp_data); end
        checks++; if (ns_wr_count != 0 || ns_mem[0] !== 32'h0) begin failures++; $display("FAIL ns_sw_mem: got %0d/%h expected 0/0", ns_wr_count, ns_mem[0]); end
        issue(1'b1, 1'b1, 3'b010, 32'h4, 32'h5A5A5A5A);
        wait_resp(1'b1, lat);
        checks++; if (ns_resp_error !== 1'b0 || ns_mem[1] !== 32'h5A5A5A5A) begin failures++; $display("FAIL ns_aligned_sw: got %b/%h expected 0/5a5a5a5a", ns_resp_error, ns_mem[1]); end
    endtask

    task automatic test_backpressure();
        int lat;
        resp_ready = 1'b0;
        issue(1'b0, 1'b0, 3'b010, 32'h10, 32'h0);
        wait_resp(1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hDEADBEEF) begin failures++; $display("FAIL bp_hold_%0d: got %b/%h expected 1/deadbeef", i, resp_valid, resp_data); end
            checks++; if (req_ready !== 1'b0 || mem_write_enable !== 1'b0) begin failures++; $display("FAIL bp_idle_%0d: got ready=%b we=%b expected 0/0", i, req_ready, mem_write_enable); end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL bp_release: got %b/%b expected 0/1", resp_valid, req_ready); end
    endtask

    task automatic test_reset_mid();
        int wr0;
        wr0 = wr_count;
        issue(1'b0, 1'b1, 3'b010, 32'h41, 32'h99AABBCC);
        checks++; if (mem_mask_byte !== 4'b1110 || mem_write_data !== 32'hAABBCC00) begin failures++; $display("FAIL rm_acc0: got %b/%h expected 1110/aabbcc00", mem_mask_byte, mem_write_data); end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if (mem_write_enable !== 1'b0) begin failures++; $display("FAIL rm_we_gated: got %b expected 0", mem_write_enable); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL rm_idle: got %b/%b expected 0/1", resp_valid, req_ready); end
        checks++; if (wr_count != wr0 + 1) begin failures++; $display("FAIL rm_write_count: got %0d expected 1", wr_count - wr0); end
        checks++; if (mem[8'h10] !== 32'hAABBCC11) begin failures++; $display("FAIL rm_low_word: got %h expected aabbcc11", mem[8'h10]); end
        checks++; if (mem[8'h11] !== 32'h887766AB) begin failures++; $display("FAIL rm_high_word: got %h expected 887766ab", mem[8'h11]); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int a1;
        issue(1'b0, 1'b0, 3'b010, 32'h44, 32'h0);
        a1 = accept_cyc;
        wait_resp(1'b0, lat);
        checks++; if (resp_data !== 32'h887766AB) begin failures++; $display("FAIL b2b_lw: got %h expected 887766ab", resp_data); end
        issue(1'b0, 1'b0, 3'b100, 32'h46, 32'h0);
        checks++; if (accept_cyc - a1 != 4) begin failures++; $display("FAIL b2b_spacing: got %0d expected 4", accept_cyc - a1); end
        wait_resp(1'b0, lat);
        checks++; if (resp_data !== 32'h00000077) begin failures++; $display("FAIL b2b_lbu: got %h expected 00000077", resp_data); end
        issue(1'b0, 1'b0, 3'b001, 32'h46, 32'h0);
        wait_resp(1'b0, lat);
        checks++; if (resp_data !== 32'hFFFF8877) begin failures++; $display("FAIL b2b_lh: got %h expected ffff8877", resp_data); end
        issue(1'b0, 1'b0, 3'b101, 32'h45, 32'h0);
        wait_resp(1'b0, lat);
        checks++; if (lat != 2 || resp_data !== 32'h00007766) begin failures++; $display("FAIL b2b_lhu_off1: got %0d/%h expected 2/00007766", lat, resp_data); end
        issue(1'b0, 1'b0, 3'b000, 32'h44, 32'h0);
        wait_resp(1'b0, lat);
        checks++; if (resp_data !== 32'hFFFFFFAB) begin failures++; $display("FAIL b2b_lb: got %h expected ffffffab", resp_data); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        ns_req_valid = 1'b0;
        resp_ready = 1'b1;
        req_write = 1'b0;
        req_funct3 = 3'b000;
        req_address = 32'h0;
        req_write_data = 32'h0;
        test_reset();
        test_aligned();
        test_subword();
        test_split();
        test_wrap();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the core's execute stage and the byte-lane data memory. It is the direct upstream feeder of the data memory.
- Accepts one load/store request at a time over a valid/ready handshake.
- Turns it into word-address, byte-mask and lane-aligned write-data commands, and drives the memory write enable.
- Collects read data under the memory's one-cycle read latency.
- Extracts and sign/zero-extends load results; splits lane-straddling misaligned accesses into two word accesses.

Parameters:
WIDTH, 10, byte-address width of data memory; word address is WIDTH-2 bits (must match memory)
SPLIT_MISALIGNED, 1, 1 = serve misaligned accesses (split if straddling); 0 = flag misaligned as error, no memory access

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept; request accepted when req_valid && req_ready
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
req_address  in  32  byte address; bits above WIDTH-1 ignored
req_write_data  in  32  store data, right-justified
resp_valid  out  1  response present
resp_ready  in  1  consumer takes response when resp_valid && resp_ready
resp_data  out  32  extended load result; 0 for stores and errors
resp_error  out  1  illegal funct3, or misaligned with SPLIT_MISALIGNED=0
mem_address  out  WIDTH-2  word address to memory (MemoryBus::Cmd address)
mem_write_enable  out  1  memory write strobe
mem_write_data  out  32  lane-aligned write data (MemoryBus::Cmd write_data)
mem_mask_byte  out  4  byte-lane enables (MemoryBus::Cmd mask_byte)
mem_read_data  in  32  memory read word, valid the cycle after mem_address is driven (MemoryBus::Result)

Behaviour:
- Reset (rst high on a clock edge): state = IDLE, resp_valid=0, resp_error=0, resp_data=0, mem_write_enable=0, mem_mask_byte=0. req_ready=0 while rst is high.
- Definitions: off = address[1:0]; size = 1/2/4 bytes; straddle = off+size > 4; misaligned = (H and off[0]) or (W and off != 0).
- Illegal funct3: loads 011, 110, 111; stores any value other than 000/001/010.
- Illegal or (misaligned && !SPLIT_MISALIGNED): no memory command is issued. Go IDLE -> DONE with resp_error=1 and resp_data=0.
- FSM states: IDLE, ACC0, ACC1, DONE.
- IDLE: req_ready=1. On accept, latch the request and go to ACC0 (or DONE on error).
- ACC0:
  - mem_address = address[WIDTH-1:2].
  - mem_mask_byte bits set for lanes off .. min(off+size,4)-1.
  - mem_write_data = data << 8*off.
  - mem_write_enable = req_write.
  - Next state: ACC1 if straddle, else DONE.
- ACC1:
  - mem_address = first word address + 1, wrapping modulo 2^(WIDTH-2).
  - mem_mask_byte lanes 0 .. off+size-5.
  - mem_write_data = data >> 8*(4-off).
  - mem_write_enable = req_write.
  - Capture mem_read_data as the low word; go to DONE.
- DONE:
  - Capture the final read word. Form {high,low} >> 8*off, truncate to size, then sign-extend (B, H) or zero-extend (BU, HU, W).
  - resp_valid is registered; it rises on entry to DONE and is held stable with resp_data/resp_error until resp_ready, then go to IDLE.
  - Stores return resp_data=0, resp_error=0.
- Outside ACC0/ACC1, mem_write_enable=0 and mem_mask_byte=0.
- Latency (accept edge to resp_valid): 2 cycles non-split, 3 cycles split, 1 cycle error. Throughput: one request per response handshake, plus one IDLE cycle.
- Reset mid-operation: return to IDLE immediately; no further memory writes. A split store reset between ACC0 and ACC1 leaves only its low part written; this is accepted.
- Back-pressure: resp_ready low holds DONE indefinitely with no memory activity.

Test Plan:
1. Aligned store/load: SW 0xDEADBEEF @0x10, then LW @0x10 -> ACC0 drives mem_address=4, mask=1111; load resp_data=0xDEADBEEF, 2 cycles after accept, resp_error=0.
2. Sub-word: SB 0x80 @0x21 -> mask=0010, mem_write_data=0x00008000. LB @0x21 -> 0xFFFFFF80; LBU @0x21 -> 0x00000080.
3. Split: after SW 0x44332211 @0x40 and SW 0x88776655 @0x44, LW @0x42 -> two accesses (words 0x10 then 0x11), resp_data=0x66554433, 3-cycle latency. SH 0xABCD @0x43 -> ACC0 mask=1000, data 0xCD000000; ACC1 mask=0001, data 0x000000AB.
4. Wrap: LW @0x3FE (WIDTH=10) -> second access mem_address=0.
5. Errors: funct3=011 load -> resp_error=1 after 1 cycle, no mem_write_enable. SPLIT_MISALIGNED=0 with SW @0x2 -> resp_error=1, memory unchanged.
6. Handshake/reset: hold resp_ready=0 for 5 cycles -> resp_valid/resp_data stable, req_ready=0. Assert rst during ACC1 of a split store -> no write in the following cycle, IDLE with resp_valid=0.
